// File: rtl/w0rm_core_memory.sv
// W0RM core memory: a dual-port word store with an instruction-fetch port and a data bus port.
// Define W0RM_MEM_OOR_RESP_EN to answer out-of-range requests with 32'hDEADBEEF / 16'hDEAD.
module w0rm_core_memory #(
   parameter int          BLOCK_RAM = 0,
   parameter logic [31:0] BASE_ADDR = 32'h20000000,
   parameter int          MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] inst_addr,
   input  logic        inst_read,
   input  logic        inst_valid_in,
   output logic [15:0] inst_data_out,
   output logic        inst_valid_out,
   input  logic [31:0] bus_addr,
   input  logic        bus_read,
   input  logic        bus_write,
   input  logic        bus_valid_in,
   input  logic [31:0] bus_data_in,
   output logic [31:0] bus_data_out,
   output logic        bus_valid_out
);

   localparam int          AW        = $clog2(MEM_WORDS);
   localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

`ifdef W0RM_MEM_OOR_RESP_EN
   localparam bit OOR_RESP = 1'b1;
`else
   localparam bit OOR_RESP = 1'b0;
`endif

   logic [31:0]   w_busOff;
   logic [31:0]   w_instOff;
   logic          w_busInRange;
   logic          w_instInRange;
   logic [AW-1:0] w_busIdx;
   logic [AW-1:0] w_instIdx;
   logic          w_busWe;
   logic          w_busRdReq;
   logic          w_busRdOor;
   logic          w_instReq;
   logic          w_instOor;

   // The offset compare is done in 33 bits so a window near the top of the map cannot wrap.
   assign w_busOff      = bus_addr - BASE_ADDR;
   assign w_instOff     = inst_addr - BASE_ADDR;
   assign w_busInRange  = (bus_addr >= BASE_ADDR) && ({1'b0, w_busOff} < MEM_BYTES);
   assign w_instInRange = (inst_addr >= BASE_ADDR) && ({1'b0, w_instOff} < MEM_BYTES);
   assign w_busIdx      = w_busOff[AW+1:2];
   assign w_instIdx     = w_instOff[AW+1:2];

   assign w_busWe    = !reset && bus_valid_in && bus_write && w_busInRange;
   assign w_busRdReq = bus_valid_in && bus_read && !bus_write;
   assign w_busRdOor = OOR_RESP && w_busRdReq && !w_busInRange;
   assign w_instReq  = inst_valid_in && inst_read;
   assign w_instOor  = OOR_RESP && w_instReq && !w_instInRange;

   logic [31:0] r_mem [MEM_WORDS];
   logic [31:0] r_busWord;
   logic [31:0] r_instWord;

   generate
      if (BLOCK_RAM != 0) begin : g_bram
         always_ff @(posedge clk) begin
            if (w_busWe) begin
               r_mem[w_busIdx] <= bus_data_in;
            end
            r_busWord  <= r_mem[w_busIdx];
            r_instWord <= r_mem[w_instIdx];
         end
      end else begin : g_regs
         logic [31:0] w_busRdWord;
         logic [31:0] w_instRdWord;

         assign w_busRdWord  = r_mem[w_busIdx];
         assign w_instRdWord = r_mem[w_instIdx];

         always_ff @(posedge clk) begin
            if (w_busWe) begin
               r_mem[w_busIdx] <= bus_data_in;
            end
         end

         always_ff @(posedge clk) begin
            r_busWord  <= w_busRdWord;
            r_instWord <= w_instRdWord;
         end
      end
   endgenerate

   logic r_busPend;
   logic r_busPendOor;
   logic r_instPend;
   logic r_instPendOor;
   logic r_instHi;

   // First stage: remember which requests were accepted while the word is being read.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busPend     <= 1'b0;
         r_busPendOor  <= 1'b0;
         r_instPend    <= 1'b0;
         r_instPendOor <= 1'b0;
         r_instHi      <= 1'b0;
      end else begin
         r_busPend     <= (w_busRdReq && w_busInRange) || w_busRdOor;
         r_busPendOor  <= w_busRdOor;
         r_instPend    <= (w_instReq && w_instInRange) || w_instOor;
         r_instPendOor <= w_instOor;
         r_instHi      <= inst_addr[1];
      end
   end

   logic        r_busValid;
   logic [31:0] r_busData;
   logic        r_instValid;
   logic [15:0] r_instData;

   // Output stage: data registers only load with a response, so they hold between pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busValid  <= 1'b0;
         r_busData   <= 32'h0;
         r_instValid <= 1'b0;
         r_instData  <= 16'h0;
      end else begin
         r_busValid  <= r_busPend;
         r_instValid <= r_instPend;
         if (r_busPend) begin
            r_busData <= r_busPendOor ? 32'hDEADBEEF : r_busWord;
         end
         if (r_instPend) begin
            if (r_instPendOor) begin
               r_instData <= 16'hDEAD;
            end else begin
               r_instData <= r_instHi ? r_instWord[31:16] : r_instWord[15:0];
            end
         end
      end
   end

   assign bus_valid_out  = r_busValid;
   assign bus_data_out   = r_busData;
   assign inst_valid_out = r_instValid;
   assign inst_data_out  = r_instData;

endmodule

// File: tb/tb_w0rm_core_memory.sv
// Directed testbench for w0rm_core_memory; responses appear two edges after the request edge.
module tb_w0rm_core_memory;

   logic        clk;
   logic        reset;
   logic [31:0] inst_addr;
   logic        inst_read;
   logic        inst_valid_in;
   logic [15:0] inst_data_out;
   logic        inst_valid_out;
   logic [31:0] bus_addr;
   logic        bus_read;
   logic        bus_write;
   logic        bus_valid_in;
   logic [31:0] bus_data_in;
   logic [31:0] bus_data_out;
   logic        bus_valid_out;

   int total;
   int bad;

   w0rm_core_memory dut (
      .clk            (clk),
      .reset          (reset),
      .inst_addr      (inst_addr),
      .inst_read      (inst_read),
      .inst_valid_in  (inst_valid_in),
      .inst_data_out  (inst_data_out),
      .inst_valid_out (inst_valid_out),
      .bus_addr       (bus_addr),
      .bus_read       (bus_read),
      .bus_write      (bus_write),
      .bus_valid_in   (bus_valid_in),
      .bus_data_in    (bus_data_in),
      .bus_data_out   (bus_data_out),
      .bus_valid_out  (bus_valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs at the falling edge; returns after the next falling edge.
   task automatic applyStimulus(input logic bv, input logic rd, input logic wr,
                                input logic [31:0] ba, input logic [31:0] bd,
                                input logic iv, input logic ir, input logic [31:0] ia);
      bus_valid_in  = bv;
      bus_read      = rd;
      bus_write     = wr;
      bus_addr      = ba;
      bus_data_in   = bd;
      inst_valid_in = iv;
      inst_read     = ir;
      inst_addr     = ia;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      @(negedge clk);
      idle();
      idle();
      checkOutput("rst_bv", {31'h0, bus_valid_out}, 32'h0);
      checkOutput("rst_iv", {31'h0, inst_valid_out}, 32'h0);
      checkOutput("rst_bd", bus_data_out, 32'h0);
      checkOutput("rst_id", {16'h0, inst_data_out}, 32'h0);
      reset = 1'b0;
      idle();

      // Basic write then read.
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h20000000, 32'h12345678, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h20000000, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("wr_noresp", {31'h0, bus_valid_out}, 32'h0);
      idle();
      checkOutput("rd0_v", {31'h0, bus_valid_out}, 32'h1);
      checkOutput("rd0_d", bus_data_out, 32'h12345678);
      idle();
      checkOutput("rd0_pulse", {31'h0, bus_valid_out}, 32'h0);
      checkOutput("rd0_hold", bus_data_out, 32'h12345678);

      // Back-to-back reads.
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h20000004, 32'hCAFEBABE, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h20000004, 32'h0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h20000000, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("b2b1_v", {31'h0, bus_valid_out}, 32'h1);
      checkOutput("b2b1_d", bus_data_out, 32'hCAFEBABE);
      idle();
      checkOutput("b2b2_v", {31'h0, bus_valid_out}, 32'h1);
      checkOutput("b2b2_d", bus_data_out, 32'h12345678);
      idle();
      checkOutput("b2b_end", {31'h0, bus_valid_out}, 32'h0);

      // Halfword fetches.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20000004);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20000006);
      checkOutput("f_lo_v", {31'h0, inst_valid_out}, 32'h1);
      checkOutput("f_lo_d", {16'h0, inst_data_out}, 32'h0000BABE);
      idle();
      checkOutput("f_hi_v", {31'h0, inst_valid_out}, 32'h1);
      checkOutput("f_hi_d", {16'h0, inst_data_out}, 32'h0000CAFE);
      idle();
      checkOutput("f_pulse", {31'h0, inst_valid_out}, 32'h0);
      checkOutput("f_hold", {16'h0, inst_data_out}, 32'h0000CAFE);

      // Out-of-range reads just below and just above the window.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h1FFFFFFC, 32'h0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h20001000, 32'h0, 1'b1, 1'b1, 32'h20001000);
`ifdef W0RM_MEM_OOR_RESP_EN
      checkOutput("oor_lo_v", {31'h0, bus_valid_out}, 32'h1);
      checkOutput("oor_lo_d", bus_data_out, 32'hDEADBEEF);
      idle();
      checkOutput("oor_hi_v", {31'h0, bus_valid_out}, 32'h1);
      checkOutput("oor_hi_d", bus_data_out, 32'hDEADBEEF);
      checkOutput("oor_f_v", {31'h0, inst_valid_out}, 32'h1);
      checkOutput("oor_f_d", {16'h0, inst_data_out}, 32'h0000DEAD);
`else
      checkOutput("oor_lo_v", {31'h0, bus_valid_out}, 32'h0);
      idle();
      checkOutput("oor_hi_v", {31'h0, bus_valid_out}, 32'h0);
      checkOutput("oor_hold", bus_data_out, 32'h12345678);
      checkOutput("oor_f_v", {31'h0, inst_valid_out}, 32'h0);
      checkOutput("oor_f_hold", {16'h0, inst_data_out}, 32'h0000CAFE);
`endif
      idle();
      checkOutput("oor_end", {31'h0, bus_valid_out}, 32'h0);

      // Read and write together: write wins, no response.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h20000008, 32'h11112222, 1'b0, 1'b0, 32'h0);
      idle();
      checkOutput("rw_noresp", {31'h0, bus_valid_out}, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h20000008, 32'h0, 1'b0, 1'b0, 32'h0);
      idle();
      checkOutput("rw_rd_v", {31'h0, bus_valid_out}, 32'h1);
      checkOutput("rw_rd_d", bus_data_out, 32'h11112222);

      // A read without bus_valid_in is ignored.
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h20000004, 32'h0, 1'b0, 1'b0, 32'h0);
      idle();
      checkOutput("inval_v", {31'h0, bus_valid_out}, 32'h0);
      checkOutput("inval_hold", bus_data_out, 32'h11112222);

      // Same-cycle write and fetch of one word returns the old data.
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h20000000, 32'h0000AAAA, 1'b1, 1'b1, 32'h20000000);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20000000);
      checkOutput("wf_old_v", {31'h0, inst_valid_out}, 32'h1);
      checkOutput("wf_old_d", {16'h0, inst_data_out}, 32'h00005678);
      idle();
      checkOutput("wf_new_v", {31'h0, inst_valid_out}, 32'h1);
      checkOutput("wf_new_d", {16'h0, inst_data_out}, 32'h0000AAAA);

      // Reset kills a pending read and blocks a write issued under reset.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h20000004, 32'h0, 1'b0, 1'b0, 32'h0);
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h20000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0);
      checkOutput("rstp_bv", {31'h0, bus_valid_out}, 32'h0);
      checkOutput("rstp_bd", bus_data_out, 32'h0);
      checkOutput("rstp_id", {16'h0, inst_data_out}, 32'h0);
      reset = 1'b0;
      idle();
      checkOutput("rstp_sup", {31'h0, bus_valid_out}, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h20000004, 32'h0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h20000000, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("ret4_v", {31'h0, bus_valid_out}, 32'h1);
      checkOutput("ret4_d", bus_data_out, 32'hCAFEBABE);
      idle();
      checkOutput("ret0_v", {31'h0, bus_valid_out}, 32'h1);
      checkOutput("ret0_d", bus_data_out, 32'h0000AAAA);
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
